// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial stage feeding the 1010 sequence detector: accepts WIDTH-bit
// words over valid/ready and shifts them out MSB-first, with an optional idle gap.
module serial_bit_feeder #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned GAP      = 0,
   parameter logic        IDLE_BIT = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             last_bit,
   output logic             busy
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] BIT_LOAD = CW'(WIDTH - 1);
   localparam logic [3:0]    GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_GAP
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    bitcnt;
   logic [3:0]       gapcnt;
   logic             bit0;
   logic             accept;

   assign bit0   = (bitcnt == '0);
   assign accept = din_valid && din_ready;

   // Ready is also raised on the bit-0 cycle when GAP is 0 so words stream seamlessly.
   always_comb begin
      din_ready = 1'b0;
      if (!reset) begin
         case (state)
            ST_IDLE:  din_ready = 1'b1;
            ST_SHIFT: din_ready = bit0 && (GAP == 0);
            default:  din_ready = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nx = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (bit0 && !accept) begin
               state_nx = (GAP > 0) ? ST_GAP : ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gapcnt == '0) begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sreg   <= '0;
         bitcnt <= '0;
         gapcnt <= '0;
      end else begin
         if (accept) begin
            sreg   <= din;
            bitcnt <= BIT_LOAD;
         end else if (state == ST_SHIFT) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
            if (!bit0) begin
               bitcnt <= bitcnt - CW'(1);
            end
         end

         if ((state == ST_SHIFT) && bit0 && !accept && (GAP > 0)) begin
            gapcnt <= GAP_LOAD;
         end else if ((state == ST_GAP) && (gapcnt != '0)) begin
            gapcnt <= gapcnt - 4'd1;
         end
      end
   end

   always_comb begin
      sout       = IDLE_BIT;
      sout_valid = 1'b0;
      last_bit   = 1'b0;
      busy       = 1'b0;
      case (state)
         ST_SHIFT: begin
            sout       = sreg[WIDTH-1];
            sout_valid = 1'b1;
            last_bit   = bit0;
            busy       = 1'b1;
         end
         ST_GAP: begin
            busy = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: two instances (GAP=0 and GAP=2) driven by the same
// directed stimulus, checked every cycle against a symbol-queue model.
module tb_serial_bit_feeder;

   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             so [2];
   logic             sv [2];
   logic             lb [2];
   logic             bz [2];
   logic             rd [2];

   int n_chk  = 0;
   int n_fail = 0;
   int cycn   = 0;
   bit chk_en = 1'b0;

   // Model: each accepted word becomes WIDTH data symbols plus GAP idle symbols
   // {valid, bit, last}; one symbol is presented per cycle.
   int         gapv [2] = '{0, 2};
   logic [2:0] mbuf [2][64];
   int         mhead [2] = '{0, 0};
   int         mcnt  [2] = '{0, 0};
   logic [2:0] cur  [2];
   bit         curv [2] = '{0, 0};

   bit s0[$];
   bit s2[$];
   int t0[$];
   int t2[$];

   always #5 clk = ~clk;

   serial_bit_feeder #(.WIDTH(WIDTH), .GAP(0), .IDLE_BIT(1'b1)) dut0 (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rd[0]),
      .sout(so[0]), .sout_valid(sv[0]), .last_bit(lb[0]), .busy(bz[0]));

   serial_bit_feeder #(.WIDTH(WIDTH), .GAP(2), .IDLE_BIT(1'b1)) dut2 (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rd[1]),
      .sout(so[1]), .sout_valid(sv[1]), .last_bit(lb[1]), .busy(bz[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit mready(input int d);
      if (reset) return 1'b0;
      if (!curv[d]) return 1'b1;
      return (gapv[d] == 0) && cur[d][0] && (mcnt[d] == 0);
   endfunction

   function automatic int unsigned qv(input bit q[$]);
      int unsigned v = 0;
      foreach (q[i]) v = (v << 1) | 32'(q[i]);
      return v;
   endfunction

   function automatic int count1010(input bit q[$]);
      int n = 0;
      for (int i = 0; i + 3 < q.size(); i++) begin
         if (q[i] && !q[i+1] && q[i+2] && !q[i+3]) n++;
      end
      return n;
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            mcnt[d] = 0;
            curv[d] = 1'b0;
         end else begin
            if (din_valid && mready(d)) begin
               for (int b = WIDTH - 1; b >= 0; b--) begin
                  mbuf[d][(mhead[d] + mcnt[d]) % 64] = {1'b1, din[b], (b == 0)};
                  mcnt[d]++;
               end
               for (int g = 0; g < gapv[d]; g++) begin
                  mbuf[d][(mhead[d] + mcnt[d]) % 64] = 3'b010;
                  mcnt[d]++;
               end
            end
            if (mcnt[d] > 0) begin
               cur[d]   = mbuf[d][mhead[d]];
               curv[d]  = 1'b1;
               mhead[d] = (mhead[d] + 1) % 64;
               mcnt[d]--;
            end else begin
               curv[d] = 1'b0;
            end
         end
      end
      cycn++;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("sout[%0d]", d),       32'(so[d]), 32'(curv[d] ? cur[d][1] : 1'b1));
            chk($sformatf("sout_valid[%0d]", d), 32'(sv[d]), 32'(curv[d] & cur[d][2]));
            chk($sformatf("last_bit[%0d]", d),   32'(lb[d]), 32'(curv[d] & cur[d][0]));
            chk($sformatf("busy[%0d]", d),       32'(bz[d]), 32'(curv[d]));
            chk($sformatf("din_ready[%0d]", d),  32'(rd[d]), 32'(mready(d)));
         end
         if (sv[0] === 1'b1) begin s0.push_back(so[0]); t0.push_back(cycn); end
         if (sv[1] === 1'b1) begin s2.push_back(so[1]); t2.push_back(cycn); end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic clr();
      s0.delete(); s2.delete(); t0.delete(); t2.delete();
   endtask

   initial begin
      int rel;
      reset = 1'b1; din = '0; din_valid = 1'b0;
      @(posedge clk); #2;
      @(negedge clk);
      chk("rst_busy", 32'(bz[0]), 32'd0);
      chk("rst_valid", 32'(sv[0]), 32'd0);
      chk("rst_sout", 32'(so[0]), 32'd1);
      chk("rst_ready", 32'(rd[0]), 32'd0);
      chk_en = 1'b1;
      cyc(1);
      reset = 1'b0;
      cyc(1);

      // single word A5
      clr(); din = 8'hA5; din_valid = 1'b1; cyc(1); din_valid = 1'b0; cyc(10);
      chk("a5_len", 32'(s0.size()), 32'd8);
      chk("a5_val", qv(s0), 32'hA5);

      // back-to-back AA then 55
      clr(); din = 8'hAA; din_valid = 1'b1; cyc(1); din = 8'h55; cyc(8); din_valid = 1'b0; cyc(12);
      chk("b2b_len", 32'(s0.size()), 32'd16);
      chk("b2b_val", qv(s0), 32'hAA55);
      chk("b2b_contig", 32'(t0[15] - t0[0]), 32'd15);
      chk("b2b_1010", 32'(count1010(s0)), 32'd5);

      // GAP=2 instance: F0 then 0F, held valid
      clr(); din = 8'hF0; din_valid = 1'b1; cyc(1); din = 8'h0F; cyc(11); din_valid = 1'b0; cyc(14);
      chk("gap_len", 32'(s2.size()), 32'd16);
      chk("gap_val", qv(s2), 32'hF00F);
      chk("gap_spacing", 32'(t2[8] - t2[7]), 32'd4);

      // new word presented while busy
      clr(); din = 8'hA5; din_valid = 1'b1; cyc(1); din_valid = 1'b0; cyc(2);
      din = 8'h3C; din_valid = 1'b1; cyc(6); din_valid = 1'b0; cyc(12);
      chk("hold_len", 32'(s0.size()), 32'd16);
      chk("hold_val", qv(s0), 32'hA53C);

      // reset mid-word
      clr(); din = 8'hA5; din_valid = 1'b1; cyc(1); din_valid = 1'b0; cyc(2);
      reset = 1'b1; cyc(1); reset = 1'b0; cyc(3);
      chk("mid_rst_len", 32'(s0.size()), 32'd3);
      chk("mid_rst_val", qv(s0), 32'h5);
      clr(); din = 8'h3C; din_valid = 1'b1; cyc(1); din_valid = 1'b0; cyc(10);
      chk("post_rst_val", qv(s0), 32'h3C);
      chk("post_rst_len", 32'(s0.size()), 32'd8);

      // reset together with valid
      clr(); reset = 1'b1; din = 8'h96; din_valid = 1'b1; cyc(2);
      chk("rst_acc_none", 32'(s0.size()), 32'd0);
      reset = 1'b0; rel = cycn; cyc(1); din_valid = 1'b0; cyc(10);
      chk("rst_acc_val", qv(s0), 32'h96);
      chk("rst_acc_first", 32'(t0[0]), 32'(rel + 1));

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
